// File: rtl/mem_sp_param_if.sv
// Request/response bundle between the CPU control unit and the single-port RAM.
interface mem_sp_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd;
  logic                  wr;
  logic                  rd_valid;
  logic                  busy;
  logic                  err;

  modport master (
    output addr, data_in, rd, wr,
    input  data_out, rd_valid, busy, err
  );

  modport slave (
    input  addr, data_in, rd, wr,
    output data_out, rd_valid, busy, err
  );
endinterface

// File: rtl/mem_sp_param.sv
// Parametrised single-port synchronous RAM with post-reset clear sweep,
// read-valid strobe and rejected-request flagging.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_CLEAR | sweeping CLEAR_VALUE into every word; requests ignored
//   S_IDLE  | serving single-cycle reads and writes
module mem_sp_param #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 5,
  parameter int                    DEPTH          = 32,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic           clk,
  input logic           rst,
  mem_sp_param_if.slave bus
);

  localparam int                    PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q, rd_valid_d;
  logic                  err_q, err_d;
  logic                  mem_we;
  logic [PTR_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_en;
  logic                  in_range;
  logic [PTR_W-1:0]      addr_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign in_range = ({1'b0, bus.addr} < DEPTH_L);
  assign addr_idx = bus.addr[PTR_W-1:0];

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_idx;
    mem_wdata  = bus.data_in;
    rd_en      = 1'b0;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = CLEAR_VALUE;
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = S_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.rd || bus.wr) begin
          if ((bus.rd && bus.wr) || !in_range) begin
            err_d = 1'b1;
          end else if (bus.wr) begin
            mem_we = 1'b1;
          end else begin
            rd_en      = 1'b1;
            rd_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request or sweep step coinciding with reset must not touch the array.
    if (rst) begin
      mem_we = 1'b0;
      rd_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_ptr_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      if (rd_en) data_out_q <= mem[addr_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q == S_CLEAR);

endmodule

// File: tb/tb_mem_sp_param.sv
// Directed bench for mem_sp_param: default 32x8 with clear, 10x16 in a 4-bit
// address space, and a no-clear variant.
module tb_mem_sp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   total = 0;
  int   bad   = 0;

  mem_sp_param_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(5)) if0 ();
  mem_sp_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) if1 ();
  mem_sp_param_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(5)) if2 ();

  mem_sp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00))
    u0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  mem_sp_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(10), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h0000))
    u1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  mem_sp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(8'h00))
    u2 (.clk(clk), .rst(rst2), .bus(if2.slave));

  typedef struct {
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rv;
    logic       err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    if0.rd = r; if0.wr = w; if0.addr = a; if0.data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    if1.rd = r; if1.wr = w; if1.addr = a; if1.data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic drive2(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    if2.rd = r; if2.wr = w; if2.addr = a; if2.data_in = d;
    @(posedge clk); #1;
  endtask

  function automatic logic busy_of(input int which);
    case (which)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  // Call right after rst falls at a negedge; counts edges until busy drops.
  task automatic wait_idle(input int which, input int exp, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy_of(which) && n < 200);
    chk(name, 32'(n), 32'(exp));
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b0, 1'b1, 5'd5,  8'hA5, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 5'd5,  8'h00, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 5'd5,  8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 5'd7,  8'h3C, 8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 5'd7,  8'hFF, 8'hA5, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 5'd7,  8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 5'd7,  8'h00, 8'h3C, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 5'd31, 8'hC3, 8'h3C, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 5'd31, 8'h00, 8'hC3, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 5'd0,  8'h11, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h11, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 5'd0,  8'h22, 8'h11, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h11, 1'b0, 1'b0};

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.rd = 1'b0; if0.wr = 1'b0; if0.addr = '0; if0.data_in = '0;
    if1.rd = 1'b0; if1.wr = 1'b0; if1.addr = '0; if1.data_in = '0;
    if2.rd = 1'b0; if2.wr = 1'b0; if2.addr = '0; if2.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout0",  32'(if0.data_out), 32'h0);
    chk("rst_rv0",    32'(if0.rd_valid), 32'h0);
    chk("rst_err0",   32'(if0.err),      32'h0);
    chk("rst_busy0",  32'(if0.busy),     32'h1);
    chk("rst_busy1",  32'(if1.busy),     32'h1);
    chk("rst_busy2",  32'(if2.busy),     32'h0);

    // Sweep on the default instance with requests that must be ignored.
    @(negedge clk);
    rst0 = 1'b0;
    n = 0;
    do begin
      if (n % 2 == 0) begin
        if0.rd = 1'b1; if0.wr = 1'b0; if0.addr = 5'd3;
      end else begin
        if0.rd = 1'b0; if0.wr = 1'b1; if0.addr = 5'd4; if0.data_in = 8'hFF;
      end
      @(posedge clk); #1;
      n++;
      chk("busy_quiet", 32'({if0.rd_valid, if0.err}), 32'h0);
      if (if0.busy) @(negedge clk);
    end while (if0.busy && n < 200);
    chk("sweep_len32", 32'(n), 32'd32);

    for (int a = 0; a < 32; a++) begin
      drive0(1'b1, 1'b0, 5'(a), 8'h00);
      chk("clear_read", 32'(if0.data_out), 32'h0);
      chk("clear_rv",   32'(if0.rd_valid), 32'h1);
    end

    for (int i = 0; i < 14; i++) begin
      drive0(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
      chk("vec_dout", 32'(if0.data_out), 32'(vecs[i].dout));
      chk("vec_rv",   32'(if0.rd_valid), 32'(vecs[i].rv));
      chk("vec_err",  32'(if0.err),      32'(vecs[i].err));
      chk("vec_busy", 32'(if0.busy),     32'h0);
    end

    // Reset mid-sweep restarts a full sweep.
    @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk); #1;
    chk("rerst_dout", 32'(if0.data_out), 32'h0);
    chk("rerst_busy", 32'(if0.busy),     32'h1);
    @(negedge clk);
    rst0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_at_10", 32'(if0.busy), 32'h1);
    @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst0 = 1'b0;
    wait_idle(0, 32, "restart_sweep");
    drive0(1'b1, 1'b0, 5'd7, 8'h00);
    chk("swept_7", 32'(if0.data_out), 32'h0);

    // Write coinciding with reset.
    @(negedge clk);
    rst0 = 1'b1;
    if0.rd = 1'b0; if0.wr = 1'b1; if0.addr = 5'd2; if0.data_in = 8'h77;
    @(posedge clk); #1;
    chk("rst_wr_quiet", 32'({if0.rd_valid, if0.err}), 32'h0);
    @(negedge clk);
    rst0 = 1'b0;
    if0.wr = 1'b0;
    wait_idle(0, 32, "rst_wr_sweep");
    drive0(1'b1, 1'b0, 5'd2, 8'h00);
    chk("rst_wr_addr2", 32'(if0.data_out), 32'h0);

    // 10 x 16 in a 16-word address space.
    @(negedge clk);
    rst1 = 1'b0;
    wait_idle(1, 10, "sweep_len10");
    drive1(1'b0, 1'b1, 4'd12, 16'hBEEF);
    chk("oor_wr_err",  32'(if1.err),      32'h1);
    chk("oor_wr_rv",   32'(if1.rd_valid), 32'h0);
    chk("oor_wr_dout", 32'(if1.data_out), 32'h0);
    drive1(1'b0, 1'b0, 4'd0, 16'h0000);
    chk("oor_err_pulse", 32'(if1.err), 32'h0);
    drive1(1'b1, 1'b0, 4'd12, 16'h0000);
    chk("oor_rd_err",  32'(if1.err),      32'h1);
    chk("oor_rd_rv",   32'(if1.rd_valid), 32'h0);
    chk("oor_rd_dout", 32'(if1.data_out), 32'h0);
    drive1(1'b0, 1'b1, 4'd10, 16'h1111);
    chk("oor_edge_err", 32'(if1.err), 32'h1);
    for (int a = 0; a < 10; a++) begin
      drive1(1'b1, 1'b0, 4'(a), 16'h0000);
      chk("d10_read", 32'(if1.data_out), 32'h0);
      chk("d10_rv",   32'(if1.rd_valid), 32'h1);
    end
    drive1(1'b0, 1'b1, 4'd9, 16'h1234);
    chk("last_wr_err", 32'(if1.err), 32'h0);
    drive1(1'b1, 1'b0, 4'd9, 16'h0000);
    chk("last_rd", 32'(if1.data_out), 32'h1234);
    drive1(1'b1, 1'b0, 4'd15, 16'h0000);
    chk("oor15_err",  32'(if1.err),      32'h1);
    chk("oor15_hold", 32'(if1.data_out), 32'h1234);
    drive1(1'b0, 1'b0, 4'd0, 16'h0000);

    // No-clear variant: usable at the first edge after reset.
    @(negedge clk);
    rst2 = 1'b0;
    drive2(1'b0, 1'b1, 5'd0, 8'h5A);
    chk("nc_busy", 32'(if2.busy), 32'h0);
    chk("nc_err",  32'(if2.err),  32'h0);
    drive2(1'b1, 1'b0, 5'd0, 8'h00);
    chk("nc_rd",    32'(if2.data_out), 32'h5A);
    chk("nc_rd_rv", 32'(if2.rd_valid), 32'h1);
    drive2(1'b0, 1'b1, 5'd2, 8'h33);
    @(negedge clk);
    rst2 = 1'b1;
    if2.rd = 1'b0; if2.wr = 1'b1; if2.addr = 5'd2; if2.data_in = 8'h77;
    @(posedge clk); #1;
    chk("nc_rst_busy", 32'(if2.busy),     32'h0);
    chk("nc_rst_dout", 32'(if2.data_out), 32'h0);
    @(negedge clk);
    rst2 = 1'b0;
    if2.wr = 1'b0;
    drive2(1'b1, 1'b0, 5'd2, 8'h00);
    chk("nc_rst_wr_dropped", 32'(if2.data_out), 32'h33);
    drive2(1'b0, 1'b0, 5'd0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_sp_param.md
Name: mem_sp_param

Overview:
- Parametrised single-port synchronous RAM; the next-generation CPU data/program store, replacing the fixed 32x8 array.
- Generalised in data width, address width and depth.
- Adds synchronous reset, a post-reset clear sequencer with a busy indication, a read-valid strobe, and error flagging for rd/wr conflicts and out-of-range addresses.
- Sits between the CPU control unit and the address/data buses.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
ADDR_WIDTH, 5, address bus width in bits (>=1)
DEPTH, 32, number of words implemented; 1 <= DEPTH <= 2**ADDR_WIDTH
CLEAR_ON_RESET, 1, 1 = sweep all words to CLEAR_VALUE after reset; 0 = no sweep, contents undefined
CLEAR_VALUE, 0, word written to each location during the clear sweep (DATA_WIDTH bits)

Ports:
clk       input   1           clock; all state updates on the rising edge
rst       input   1           synchronous reset, active-high
addr      input   ADDR_WIDTH  word address
data_in   input   DATA_WIDTH  write data
data_out  output  DATA_WIDTH  registered read data; holds its value between reads
rd        input   1           read request
wr        input   1           write request
rd_valid  output  1           1-cycle pulse: data_out was updated by a read at this edge
busy      output  1           clear sweep in progress; requests ignored
err       output  1           1-cycle pulse: the request sampled at the previous edge was rejected

Behaviour:
- Reset. The reset is synchronous and active-high: any rising clk edge with rst=1 sets:
  - data_out=0, rd_valid=0, err=0;
  - state=CLEAR if CLEAR_ON_RESET=1, else IDLE;
  - clr_ptr=0;
  - busy=CLEAR_ON_RESET.
  - A request presented at a reset edge is dropped; memory is not written.
- FSM states are CLEAR and IDLE.
- CLEAR:
  - At each edge with rst=0, write CLEAR_VALUE to mem[clr_ptr] and increment clr_ptr.
  - At the edge that writes location DEPTH-1, go to IDLE and set busy=0.
  - busy is therefore high for exactly DEPTH edges after rst falls.
  - rd/wr are ignored in CLEAR: no memory access, rd_valid=0, err=0.
  - A reset in the middle of a sweep restarts it at clr_ptr=0.
- IDLE, evaluated at each rising edge with rst=0:
  - wr=1, rd=0, addr<DEPTH: mem[addr]<=data_in. rd_valid=0, err=0.
  - rd=1, wr=0, addr<DEPTH: data_out<=mem[addr]. rd_valid=1, err=0.
    - Read latency is 1 edge.
    - A read at edge N+1 following a write at edge N returns the new data.
  - rd=1 and wr=1: no memory access, data_out unchanged, rd_valid=0, err=1.
  - rd or wr with addr>=DEPTH: no memory access, data_out unchanged, rd_valid=0, err=1.
    - Only possible when DEPTH < 2**ADDR_WIDTH.
  - rd=0, wr=0: rd_valid=0, err=0, data_out holds.
- rd_valid and err are registered, mutually exclusive, and never high in the same cycle as busy.
- No wrap-around of addr. clr_ptr is sized to count to DEPTH-1 and is never compared beyond it.
- Memory is an inferable synchronous-read array; data_out is driven only from the registered read path.

Test Plan:
1. Reset clear, default parameters:
   - Stimulus: rst=1 for 2 edges, then 0; then read all 32 addresses once busy=0.
   - Required: busy=1 for exactly 32 edges after rst falls; every read returns 8'h00 with rd_valid=1.
2. Write then read-back:
   - Stimulus: wr addr=5 data=8'hA5 at edge N; rd addr=5 at edge N+1.
   - Required: data_out=8'hA5 and rd_valid=1 after edge N+1; data_out holds 8'hA5 with rd_valid=0 at edge N+2 when rd=0.
3. Conflict:
   - Stimulus: after writing 8'h3C to addr 7, drive rd=1, wr=1, addr=7, data_in=8'hFF.
   - Required: err=1 for one cycle, rd_valid=0, data_out unchanged; a later rd addr=7 returns 8'h3C.
4. Out-of-range, DATA_WIDTH=16, ADDR_WIDTH=4, DEPTH=10:
   - Stimulus: wr addr=12 data=16'hBEEF, then rd addr=12.
   - Required: err pulses on both, no rd_valid, data_out unchanged; all locations 0..9 still read 16'h0000.
5. Requests while busy:
   - Stimulus: rd addr=3 and wr addr=4 driven during the CLEAR sweep.
   - Required: no rd_valid, no err, no write; after busy=0, addr 4 reads CLEAR_VALUE.
6. Reset mid-sweep / mid-write, DEPTH=32:
   - Stimulus: assert rst 10 edges into the sweep; assert rst at the same edge as wr addr=2 data=8'h77.
   - Required: busy restarts a full 32-edge sweep; addr 2 reads 8'h00. With CLEAR_ON_RESET=0, busy=0 at the first edge after reset and a write/read of 8'h5A to addr 0 works immediately.
